// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Boot sequencer for the CPU program-load port. A host pushes a byte stream
// (valid/ready, little-endian word packing). The first word is a header that
// carries the instruction and data word counts plus a magic tag. The words
// after it are written into the CPU instruction memory first, then into the
// data memory. The CPU is held in reset for the whole load. It is released a
// fixed number of cycles after the last write.
//
// Ports
//   clk               system clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   start             1-cycle pulse, begins a new load (IDLE, RUN, ERROR only)
//   in_valid/in_data  incoming byte stream
//   in_ready          byte accepted on a cycle where in_valid & in_ready
//   cpu_rst           reset line of the CPU
//   inst_data         word presented to the CPU load port
//   address           word index presented to the CPU load port
//   write_instruction 1-cycle strobe, write inst_data to instruction memory
//   write_data        1-cycle strobe, write inst_data to data memory
//   done              image loaded and CPU running
//   error             header was rejected
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int         ADDR_W        = 10,
  parameter int         DEPTH         = 1024,
  parameter int         RELEASE_DELAY = 4,
  parameter logic [4:0] MAGIC         = 5'b10101
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              cpu_rst,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] address,
  output logic              write_instruction,
  output logic              write_data,
  output logic              done,
  output logic              error
);

  // The header count fields are 11 bits wide. DEPTH is compared in that width.
  localparam logic [10:0] DEPTH_L   = 11'(DEPTH);
  localparam logic [3:0]  REL_LAST  = 4'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LD_INST,
    S_LD_DATA,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  // Byte packer. It holds the three most recent bytes of the word being
  // assembled. The oldest byte sits at the bottom.
  logic [23:0] pack_q, pack_d;
  logic [1:0]  pack_cnt_q, pack_cnt_d;

  logic [10:0] n_inst_q, n_inst_d;
  logic [10:0] n_data_q, n_data_d;
  logic [10:0] idx_q, idx_d;
  logic [3:0]  rel_cnt_q, rel_cnt_d;

  logic [31:0]       inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              wr_inst_q, wr_inst_d;
  logic              wr_data_q, wr_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        accept;
  logic        word_done;
  logic [31:0] word_full;
  logic [10:0] hdr_n_inst;
  logic [10:0] hdr_n_data;
  logic [4:0]  hdr_magic;
  logic        hdr_bad;

  assign accept     = in_valid & in_ready_q;
  assign word_done  = accept && (pack_cnt_q == 2'd3);
  // The fourth byte of a word lands in bits [31:24].
  assign word_full  = {in_data, pack_q};
  assign hdr_n_inst = word_full[10:0];
  assign hdr_n_data = word_full[26:16];
  assign hdr_magic  = word_full[31:27];
  assign hdr_bad    = (hdr_magic != MAGIC) || (hdr_n_inst > DEPTH_L) ||
                      (hdr_n_data > DEPTH_L);

  // Next-state and next-output logic. Every registered output is computed
  // from the state being entered, so the outputs always match that state.
  always_comb begin
    state_d     = state_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    n_inst_d    = n_inst_q;
    n_data_d    = n_data_q;
    idx_d       = idx_q;
    rel_cnt_d   = '0;
    inst_data_d = inst_data_q;
    address_d   = address_q;
    wr_inst_d   = 1'b0;
    wr_data_d   = 1'b0;

    if (accept) begin
      pack_d     = {in_data, pack_q[23:8]};
      pack_cnt_d = pack_cnt_q + 2'd1;
    end

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR;
          pack_d     = '0;
          pack_cnt_d = '0;
        end
      end

      S_HDR: begin
        if (word_done) begin
          if (hdr_bad) begin
            state_d = S_ERROR;
          end else begin
            n_inst_d = hdr_n_inst;
            n_data_d = hdr_n_data;
            idx_d    = '0;
            if (hdr_n_inst != 11'd0) begin
              state_d = S_LD_INST;
            end else if (hdr_n_data != 11'd0) begin
              state_d = S_LD_DATA;
            end else begin
              state_d = S_RELEASE;
            end
          end
        end
      end

      S_LD_INST: begin
        if (word_done) begin
          inst_data_d = word_full;
          address_d   = ADDR_W'(idx_q);
          wr_inst_d   = 1'b1;
          if (idx_q == n_inst_q - 11'd1) begin
            idx_d   = '0;
            state_d = (n_data_q != 11'd0) ? S_LD_DATA : S_RELEASE;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

      S_LD_DATA: begin
        if (word_done) begin
          inst_data_d = word_full;
          address_d   = ADDR_W'(idx_q);
          wr_data_d   = 1'b1;
          if (idx_q == n_data_q - 11'd1) begin
            idx_d   = '0;
            state_d = S_RELEASE;
          end else begin
            idx_d = idx_q + 11'd1;
          end
        end
      end

      S_RELEASE: begin
        // The count starts on the cycle the last write strobe is high.
        // RUN is therefore entered exactly RELEASE_DELAY cycles after it.
        if (rel_cnt_q == REL_LAST) begin
          state_d = S_RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_LD_INST) ||
                 (state_d == S_LD_DATA);
    cpu_rst_d  = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERROR);
  end

  // State and output registers. A reset in the middle of a load drops
  // everything, including a partially packed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      n_inst_q    <= '0;
      n_data_q    <= '0;
      idx_q       <= '0;
      rel_cnt_q   <= '0;
      inst_data_q <= '0;
      address_q   <= '0;
      wr_inst_q   <= 1'b0;
      wr_data_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      n_inst_q    <= n_inst_d;
      n_data_q    <= n_data_d;
      idx_q       <= idx_d;
      rel_cnt_q   <= rel_cnt_d;
      inst_data_q <= inst_data_d;
      address_q   <= address_d;
      wr_inst_q   <= wr_inst_d;
      wr_data_q   <= wr_data_d;
      cpu_rst_q   <= cpu_rst_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // A restart from RUN must put the CPU back into reset on the start cycle.
  // It cannot wait for the state register to change.
  assign cpu_rst           = cpu_rst_q | ((state_q == S_RUN) & start);
  assign in_ready          = in_ready_q;
  assign inst_data         = inst_data_q;
  assign address           = address_q;
  assign write_instruction = wr_inst_q;
  assign write_data        = wr_data_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule
